// File: rtl/td4_sequencer_pkg.sv
// Shared definitions for the TD4 sequencer: state encoding, opcode map,
// datapath source selects and the bundled control-strobe word.
package td4_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC      = 4'b1110;
   localparam logic [3:0] OP_JMP      = 4'b1111;

   localparam logic [1:0] SEL_A    = 2'd0;
   localparam logic [1:0] SEL_B    = 2'd1;
   localparam logic [1:0] SEL_IN   = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   typedef struct packed {
      logic [1:0] mux_sel;
      logic       load_a;
      logic       load_b;
      logic       load_out;
      logic       load_pc;
      logic       pc_inc;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/td4_sequencer_if.sv
// Program-ROM fetch handshake between the sequencer (master) and the ROM (slave).
interface td4_sequencer_if;
   logic       rom_req;
   logic       rom_ack;
   logic [7:0] rom_data;

   modport master (output rom_req, input rom_ack, input rom_data);
   modport slave  (input rom_req, output rom_ack, output rom_data);
endinterface

// File: rtl/td4_sequencer_ctrl_decode.sv
// Combinational opcode decoder: IR[7:4] plus carry flag to datapath strobes.
module td4_ctrl_decode
   import td4_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       flag_c,
   output ctrl_t      ctrl
);

   // Every non-jump opcode, legal or not, advances the PC by increment.
   always_comb begin
      ctrl        = CTRL_IDLE;
      ctrl.pc_inc = 1'b1;
      case (opcode)
         OP_ADD_A_IM: begin ctrl.mux_sel = SEL_A;    ctrl.load_a   = 1'b1; end
         OP_MOV_A_B:  begin ctrl.mux_sel = SEL_B;    ctrl.load_a   = 1'b1; end
         OP_IN_A:     begin ctrl.mux_sel = SEL_IN;   ctrl.load_a   = 1'b1; end
         OP_MOV_A_IM: begin ctrl.mux_sel = SEL_ZERO; ctrl.load_a   = 1'b1; end
         OP_MOV_B_A:  begin ctrl.mux_sel = SEL_A;    ctrl.load_b   = 1'b1; end
         OP_ADD_B_IM: begin ctrl.mux_sel = SEL_B;    ctrl.load_b   = 1'b1; end
         OP_IN_B:     begin ctrl.mux_sel = SEL_IN;   ctrl.load_b   = 1'b1; end
         OP_MOV_B_IM: begin ctrl.mux_sel = SEL_ZERO; ctrl.load_b   = 1'b1; end
         OP_OUT_B:    begin ctrl.mux_sel = SEL_B;    ctrl.load_out = 1'b1; end
         OP_OUT_IM:   begin ctrl.mux_sel = SEL_ZERO; ctrl.load_out = 1'b1; end
         OP_JMP: begin
            ctrl.mux_sel = SEL_ZERO;
            ctrl.load_pc = 1'b1;
            ctrl.pc_inc  = 1'b0;
         end
         OP_JNC: begin
            if (!flag_c) begin
               ctrl.mux_sel = SEL_ZERO;
               ctrl.load_pc = 1'b1;
               ctrl.pc_inc  = 1'b0;
            end else begin
               ctrl.pc_inc  = 1'b1;
            end
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute controller: HALT/FETCH/EXEC/FAULT FSM with ROM handshake,
// timeout fault, single-step support and EXEC-gated datapath strobes.
module td4_sequencer
   import td4_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic                   halt_req,
   input  logic                   flag_c,
   td4_sequencer_if.master        rom,
   output logic [3:0]             imm,
   output logic [1:0]             mux_sel,
   output logic                   load_a,
   output logic                   load_b,
   output logic                   load_out,
   output logic                   load_pc,
   output logic                   pc_inc,
   output logic                   halted,
   output logic                   illegal,
   output logic                   fault
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] cnt_q, cnt_d;
   logic       step_q, step_d;
   ctrl_t      dec_s, ctrl_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_HALT;
         ir_q    <= 8'h00;
         cnt_q   <= 8'd0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      case (state_q)
         ST_HALT: begin
            if (step) begin
               state_d = ST_FETCH;
               step_d  = 1'b1;
            end else if (run && !halt_req) begin
               state_d = ST_FETCH;
               step_d  = 1'b0;
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_FETCH: begin
            // Counter value k means k ack-less request cycles have already elapsed.
            if (rom.rom_ack) begin
               ir_d    = rom.rom_data;
               cnt_d   = 8'd0;
               state_d = ST_EXEC;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_FAULT;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_EXEC: begin
            step_d = 1'b0;
            if (halt_req || step_q || !run) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_HALT;
      endcase
   end

   td4_ctrl_decode u_decode (
      .opcode (ir_q[7:4]),
      .flag_c (flag_c),
      .ctrl   (dec_s)
   );

   always_comb begin
      if (state_q == ST_EXEC) begin
         ctrl_s = dec_s;
      end else begin
         ctrl_s = CTRL_IDLE;
      end
   end

   assign rom.rom_req = (state_q == ST_FETCH);
   assign halted      = (state_q == ST_HALT);
   assign fault       = (state_q == ST_FAULT);
   assign imm         = ir_q[3:0];
   assign mux_sel     = ctrl_s.mux_sel;
   assign load_a      = ctrl_s.load_a;
   assign load_b      = ctrl_s.load_b;
   assign load_out    = ctrl_s.load_out;
   assign load_pc     = ctrl_s.load_pc;
   assign pc_inc      = ctrl_s.pc_inc;
   assign illegal     = ctrl_s.illegal;

endmodule
